// File: rtl/axil_bram_pkg.sv
// Shared types for the AXI4-Lite to BRAM duplex arbiter.
package axil_bram_pkg;

    // Controller states; StRmwRd is only reachable with AXIL_BRAM_ARB_RMW_EN.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdWait = 3'd1,
        StRdResp = 3'd2,
        StWrResp = 3'd3,
        StRmwRd  = 3'd4
    } state_e;

    // Which channel received the most recent grant.
    typedef enum logic {
        GrantRd = 1'b0,
        GrantWr = 1'b1
    } grant_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_bram_duplex_arbiter_if.sv
// AXI4-Lite slave bus bundle; master drives requests, slave drives readies and responses.
interface axil_bram_duplex_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH+1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH+1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_bram_byte_merge.sv
// Byte-strobe merge of a new write word over the old stored word.
module axil_bram_byte_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old,
    input  logic [DATA_WIDTH-1:0]   i_new,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_merged
);
    // Take each byte from the new word where its strobe is set.
    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
            if (i_strb[b]) begin
                o_merged[8*b +: 8] = i_new[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/axil_bram_duplex_arbiter.sv
// AXI4-Lite slave that serialises concurrent reads and writes onto one BRAM port with
// round-robin fairness. Define AXIL_BRAM_ARB_RMW_EN to honour partial write strobes via
// read-modify-write; otherwise every write stores the full word.
module axil_bram_duplex_arbiter
    import axil_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BRAM_LATENCY = 1
) (
    input  logic                      axi_clock,
    input  logic                      rst,
    axil_bram_duplex_arbiter_if.slave s_axil,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    output logic                      bram_we,
    input  logic [DATA_WIDTH-1:0]     bram_dout
);
    state_e                r_state;
    state_e                w_state_next;
    grant_e                r_last_grant;
    logic [1:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [DATA_WIDTH-1:0] r_bram_din;
    logic                  r_bram_we;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_wait_done;
    logic                  w_rmw;

    assign w_wr_req    = s_axil.awvalid && s_axil.wvalid;
    assign w_rd_req    = s_axil.arvalid;
    // Wait states span BRAM_LATENCY+1 cycles: address cycle plus the read pipeline.
    assign w_wait_done = (r_cnt == 2'(BRAM_LATENCY));

`ifdef AXIL_BRAM_ARB_RMW_EN
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_unused;

    assign w_rmw    = ~&s_axil.wstrb;
    assign w_unused = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    axil_bram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .i_old    (bram_dout),
        .i_new    (r_wdata),
        .i_strb   (r_wstrb),
        .o_merged (w_merged)
    );
`else
    logic w_unused;

    assign w_rmw    = 1'b0;
    assign w_unused = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0],
                        s_axil.wstrb};
`endif

    // State register.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_wr) begin
                    w_state_next = w_rmw ? StRmwRd : StWrResp;
                end else if (w_grant_rd) begin
                    w_state_next = StRdWait;
                end
            end
            StRdWait: if (w_wait_done) w_state_next = StRdResp;
            StRdResp: if (s_axil.rready) w_state_next = StIdle;
            StWrResp: if (s_axil.bready) w_state_next = StIdle;
            StRmwRd:  if (w_wait_done) w_state_next = StWrResp;
            default:  w_state_next = StIdle;
        endcase
    end

    // Grant outputs: only in IDLE; on a collision the channel not granted last time wins.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (!rst && r_state == StIdle) begin
            if (w_wr_req && (!w_rd_req || r_last_grant == GrantRd)) begin
                w_grant_wr = 1'b1;
            end else if (w_rd_req) begin
                w_grant_rd = 1'b1;
            end
        end
    end

    // Datapath: BRAM port, response flags, wait counter and fairness history.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            r_last_grant <= GrantRd;
            r_cnt        <= '0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_bram_we    <= 1'b0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
`ifdef AXIL_BRAM_ARB_RMW_EN
            r_wdata      <= '0;
            r_wstrb      <= '0;
`endif
        end else begin
            r_bram_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant_wr) begin
                        r_last_grant <= GrantWr;
                        r_bram_addr  <= s_axil.awaddr[ADDR_WIDTH+1:2];
                        r_cnt        <= '0;
`ifdef AXIL_BRAM_ARB_RMW_EN
                        r_wdata      <= s_axil.wdata;
                        r_wstrb      <= s_axil.wstrb;
`endif
                        if (!w_rmw) begin
                            r_bram_din <= s_axil.wdata;
                            r_bram_we  <= 1'b1;
                            r_bvalid   <= 1'b1;
                        end
                    end else if (w_grant_rd) begin
                        r_last_grant <= GrantRd;
                        r_bram_addr  <= s_axil.araddr[ADDR_WIDTH+1:2];
                        r_cnt        <= '0;
                    end
                end
                StRdWait: begin
                    if (w_wait_done) begin
                        r_rdata  <= bram_dout;
                        r_rvalid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                StRdResp: if (s_axil.rready) r_rvalid <= 1'b0;
                StWrResp: if (s_axil.bready) r_bvalid <= 1'b0;
`ifdef AXIL_BRAM_ARB_RMW_EN
                StRmwRd: begin
                    if (w_wait_done) begin
                        r_bram_din <= w_merged;
                        r_bram_we  <= 1'b1;
                        r_bvalid   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign s_axil.awready = w_grant_wr;
    assign s_axil.wready  = w_grant_wr;
    assign s_axil.arready = w_grant_rd;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = AXI_RESP_OKAY;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = AXI_RESP_OKAY;
    assign bram_addr      = r_bram_addr;
    assign bram_din       = r_bram_din;
    assign bram_we        = r_bram_we;
endmodule

// File: tb/tb_axil_bram_duplex_arbiter.sv
// Bench for axil_bram_duplex_arbiter: directed cases plus randomized traffic against a
// word-array memory model with rule-level arbitration and latency expectations.
module tb_axil_bram_duplex_arbiter;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          bram_we;

    always #5 clk = ~clk;

    axil_bram_duplex_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

    axil_bram_duplex_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BRAM_LATENCY (LAT)
    ) dut (
        .axi_clock (clk),
        .rst       (rst),
        .s_axil    (axil),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout)
    );

    // BRAM port model: synchronous write, LAT-stage read pipeline, counts write pulses.
    logic [DW-1:0] bram_mem  [0:(1<<AW)-1];
    logic [DW-1:0] bram_pipe [0:LAT-1];
    int            we_cnt;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) bram_mem[i] <= '0;
            we_cnt <= 0;
        end else if (bram_we) begin
            bram_mem[bram_addr] <= bram_din;
            we_cnt <= we_cnt + 1;
        end
        bram_pipe[0] <= bram_mem[bram_addr];
        for (int i = 1; i < int'(LAT); i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bram_dout = bram_pipe[LAT-1];

    // Reference state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            exp_last_wr;
    int            exp_we;
    bit            pend_wr;
    bit            pend_rd;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < int'(DW / 8); b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_write(input logic [AW+1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s);
        axil.awaddr  = a;
        axil.wdata   = d;
        axil.wstrb   = s;
        axil.awprot  = 3'($urandom);
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        pend_wr      = 1'b1;
    endtask

    task automatic set_read(input logic [AW+1:0] a);
        axil.araddr  = a;
        axil.arprot  = 3'($urandom);
        axil.arvalid = 1'b1;
        pend_rd      = 1'b1;
    endtask

    // Present unrelated requests while busy; none of them may be accepted.
    task automatic raise_junk(output bit jw, output bit jr);
        jw = 1'b0;
        jr = 1'b0;
        if (!pend_wr && !axil.awvalid) begin
            axil.awaddr  = (AW+2)'($urandom);
            axil.wdata   = $urandom;
            axil.wstrb   = (DW/8)'($urandom);
            axil.awvalid = 1'b1;
            axil.wvalid  = 1'b1;
            jw = 1'b1;
        end
        if (!pend_rd && !axil.arvalid) begin
            axil.araddr  = (AW+2)'($urandom);
            axil.arvalid = 1'b1;
            jr = 1'b1;
        end
    endtask

    task automatic drop_junk(input bit jw, input bit jr);
        if (jw) begin
            axil.awvalid = 1'b0;
            axil.wvalid  = 1'b0;
        end
        if (jr) axil.arvalid = 1'b0;
    endtask

    // Round-robin rule: lone request wins; on collision the channel not granted last wins.
    task automatic arbitrate(output bit win_wr);
        bit hw;
        bit hr;
        hw     = axil.awvalid && axil.wvalid;
        hr     = axil.arvalid;
        win_wr = hw && (!hr || !exp_last_wr);
        check("awready_grant", 64'(axil.awready), 64'(win_wr));
        check("wready_grant", 64'(axil.wready), 64'(win_wr));
        check("arready_grant", 64'(axil.arready), 64'(hr && !win_wr));
    endtask

    task automatic write_phase(input int bdelay);
        logic [AW-1:0] w;
        logic [DW-1:0] nv;
        int            lat;
        int            el;
        bit            jw;
        bit            jr;
        w = axil.awaddr[AW+1:2];
`ifdef AXIL_BRAM_ARB_RMW_EN
        nv = merge_bytes(ref_mem[w], axil.wdata, axil.wstrb);
        el = (axil.wstrb == '1) ? 1 : int'(LAT) + 2;
`else
        nv = axil.wdata;
        el = 1;
`endif
        step();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        pend_wr      = 1'b0;
        exp_last_wr  = 1'b1;
        ref_mem[w]   = nv;
        exp_we++;
        raise_junk(jw, jr);
        #1;
        lat = 1;
        while (!axil.bvalid && lat < 16) begin
            check("wr_busy_ready", 64'({axil.awready, axil.arready}), 64'(0));
            step();
            lat++;
        end
        check("b_latency", 64'(lat), 64'(el));
        check("bresp", 64'(axil.bresp), 64'(0));
        check("we_pulse", 64'(bram_we), 64'(1));
        check("bram_addr", 64'(bram_addr), 64'(w));
        check("bram_din", 64'(bram_din), 64'(nv));
        for (int i = 0; i <= bdelay; i++) begin
            check("b_hold", 64'({axil.bvalid, axil.awready, axil.arready}), 64'(3'b100));
            if (i > 0) check("we_single", 64'(bram_we), 64'(0));
            if (i == bdelay) begin
                axil.bready = 1'b1;
                drop_junk(jw, jr);
            end
            step();
        end
        axil.bready = 1'b0;
        check("b_done", 64'(axil.bvalid), 64'(0));
        check("we_after", 64'(bram_we), 64'(0));
    endtask

    task automatic read_phase(input int rdelay, output logic [DW-1:0] got);
        logic [AW-1:0] w;
        logic [DW-1:0] ev;
        int            lat;
        bit            jw;
        bit            jr;
        w  = axil.araddr[AW+1:2];
        ev = ref_mem[w];
        step();
        axil.arvalid = 1'b0;
        pend_rd      = 1'b0;
        exp_last_wr  = 1'b0;
        raise_junk(jw, jr);
        #1;
        lat = 1;
        while (!axil.rvalid && lat < 16) begin
            check("rd_busy_ready", 64'({axil.awready, axil.arready}), 64'(0));
            step();
            lat++;
        end
        check("r_latency", 64'(lat), 64'(LAT + 2));
        check("rdata", 64'(axil.rdata), 64'(ev));
        check("rresp", 64'(axil.rresp), 64'(0));
        got = axil.rdata;
        for (int i = 0; i <= rdelay; i++) begin
            check("r_hold", 64'({axil.rvalid, axil.awready, axil.arready}), 64'(3'b100));
            check("r_stable", 64'(axil.rdata), 64'(ev));
            if (i == rdelay) begin
                axil.rready = 1'b1;
                drop_junk(jw, jr);
            end
            step();
        end
        axil.rready = 1'b0;
        check("r_done", 64'(axil.rvalid), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            win;
        logic [DW-1:0] got;
        n_tests = 0;
        n_fail  = 0;
        exp_we  = 0;
        pend_wr = 1'b0;
        pend_rd = 1'b0;
        exp_last_wr = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        rst = 1'b1;
        mem_clr = 1'b1;
        repeat (3) step();

        // Reset state, with requests present that must not be granted.
        axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
        #1;
        check("rst_readies", 64'({axil.awready, axil.wready, axil.arready}), 64'(0));
        check("rst_valids", 64'({axil.bvalid, axil.rvalid, bram_we}), 64'(0));
        check("rst_bram_addr", 64'(bram_addr), 64'(0));
        check("rst_bram_din", 64'(bram_din), 64'(0));
        check("rst_rdata", 64'(axil.rdata), 64'(0));
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        rst = 1'b0;
        mem_clr = 1'b0;
        step();

        // Single write then read back.
        set_write(12'h010, 32'hDEADBEEF, 4'hF); #1; arbitrate(win); write_phase(0);
        set_read(12'h010); #1; arbitrate(win); read_phase(0, got);
        check("t2_rdata", 64'(got), 64'(32'hDEADBEEF));

        // Collision after reset: write first; then read against a new write.
        rst = 1'b1; step(); rst = 1'b0; exp_last_wr = 1'b0; step();
        set_write(12'h040, 32'h0BADF00D, 4'hF); set_read(12'h010); #1;
        arbitrate(win); write_phase(0);
        set_write(12'h044, 32'hCAFE0001, 4'hF); #1;
        arbitrate(win); read_phase(0, got);
        #1; arbitrate(win); write_phase(0);

        // Long response backpressure.
        set_write(12'h048, 32'h5A5A1234, 4'hF); #1; arbitrate(win); write_phase(10);
        set_read(12'h048); #1; arbitrate(win); read_phase(10, got);

        // Reset while the read is waiting on BRAM.
        set_read(12'h040); #1; arbitrate(win);
        step();
        axil.arvalid = 1'b0; pend_rd = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; exp_last_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_rvalid", 64'(axil.rvalid), 64'(0));
            step();
        end
        check("rst_mid_we_cnt", 64'(we_cnt), 64'(exp_we));
        set_read(12'h040); #1; arbitrate(win); read_phase(0, got);

        // Partial-strobe write.
        set_write(12'h080, 32'h11223344, 4'hF); #1; arbitrate(win); write_phase(0);
        set_write(12'h080, 32'hAABBCCDD, 4'b0101); #1; arbitrate(win); write_phase(1);
        set_read(12'h080); #1; arbitrate(win); read_phase(0, got);
`ifdef AXIL_BRAM_ARB_RMW_EN
        check("t6_merge", 64'(got), 64'(32'h11BB33DD));
`else
        check("t6_merge", 64'(got), 64'(32'hAABBCCDD));
`endif

        // Randomized mixed traffic.
        for (int it = 0; it < 300; it++) begin
            if (!pend_wr && $urandom_range(0, 2) == 0) begin
                set_write((AW+2)'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                          $urandom, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom));
            end
            if (!pend_rd && $urandom_range(0, 2) == 0) begin
                set_read((AW+2)'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)));
            end
            if (!pend_wr && !pend_rd) begin
                if ($urandom_range(0, 1) == 1) axil.awvalid = 1'b1;
                else axil.wvalid = 1'b1;
                #1;
                check("half_wr_ready",
                      64'({axil.awready, axil.wready, axil.arready}), 64'(0));
                step();
                axil.awvalid = 1'b0;
                axil.wvalid  = 1'b0;
            end else begin
                #1;
                arbitrate(win);
                if (win) write_phase($urandom_range(0, 3));
                else read_phase($urandom_range(0, 3), got);
            end
        end

        step();
        check("we_count", 64'(we_cnt), 64'(exp_we));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
